// File: rtl/demux_2x1_fifo_if.sv
// Handshake bundle for demux_2x1_fifo: one input stream and two buffered output streams.
// DEMUX_2X1_STATS_EN adds the per-output word counters y0_words/y1_words.
interface demux_2x1_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;

    logic              y0_valid;
    logic              y0_ready;
    logic [DATA_W-1:0] y0_data;
    logic [CNT_W-1:0]  y0_count;

    logic              y1_valid;
    logic              y1_ready;
    logic [DATA_W-1:0] y1_data;
    logic [CNT_W-1:0]  y1_count;

`ifdef DEMUX_2X1_STATS_EN
    logic [15:0]       y0_words;
    logic [15:0]       y1_words;

    modport master (
        output in_valid, in_data, in_sel, y0_ready, y1_ready,
        input  in_ready, y0_valid, y0_data, y0_count,
        input  y1_valid, y1_data, y1_count, y0_words, y1_words
    );

    modport slave (
        input  in_valid, in_data, in_sel, y0_ready, y1_ready,
        output in_ready, y0_valid, y0_data, y0_count,
        output y1_valid, y1_data, y1_count, y0_words, y1_words
    );
`else
    modport master (
        output in_valid, in_data, in_sel, y0_ready, y1_ready,
        input  in_ready, y0_valid, y0_data, y0_count,
        input  y1_valid, y1_data, y1_count
    );

    modport slave (
        input  in_valid, in_data, in_sel, y0_ready, y1_ready,
        output in_ready, y0_valid, y0_data, y0_count,
        output y1_valid, y1_data, y1_count
    );
`endif
endinterface

// File: rtl/demux_2x1_fifo.sv
// Registered 1:2 demultiplexer: each input word is routed by in_sel into one of two FWFT FIFOs.
// Optional macro DEMUX_2X1_STATS_EN adds saturating 16-bit accepted-word counters per output.
module demux_2x1_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_2x1_fifo_if.slave       bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("demux_2x1_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [PTR_W-1:0]  wr_ptr0, rd_ptr0;
    logic [PTR_W-1:0]  wr_ptr1, rd_ptr1;
    logic [CNT_W-1:0]  cnt0, cnt1;

    logic              sel_full;
    logic              in_ready;
    logic              push, push0, push1;
    logic              pop0, pop1;
    logic              y0_valid, y1_valid;

    // Head-of-line blocking: only the selected FIFO's fullness matters, with no pop bypass.
    assign sel_full = bus.in_sel ? (cnt1 == FULL_CNT) : (cnt0 == FULL_CNT);
    assign in_ready = !rst && !sel_full;

    assign y0_valid = (cnt0 != '0);
    assign y1_valid = (cnt1 != '0);

    assign push  = bus.in_valid && in_ready;
    assign push0 = push && !bus.in_sel;
    assign push1 = push &&  bus.in_sel;
    assign pop0  = !rst && y0_valid && bus.y0_ready;
    assign pop1  = !rst && y1_valid && bus.y1_ready;

    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             do_push,
        input logic             do_pop
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        case ({do_push, do_pop})
            2'b10:   res = cnt + CNT_W'(1);
            2'b01:   res = cnt - CNT_W'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Storage is data-only and deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem0[wr_ptr0] <= bus.in_data;
        end
        if (push1) begin
            mem1[wr_ptr1] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr0 <= '0;
            rd_ptr0 <= '0;
            cnt0    <= '0;
        end else begin
            if (push0) begin
                wr_ptr0 <= wr_ptr0 + PTR_W'(1);
            end
            if (pop0) begin
                rd_ptr0 <= rd_ptr0 + PTR_W'(1);
            end
            cnt0 <= next_count(cnt0, push0, pop0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr1 <= '0;
            rd_ptr1 <= '0;
            cnt1    <= '0;
        end else begin
            if (push1) begin
                wr_ptr1 <= wr_ptr1 + PTR_W'(1);
            end
            if (pop1) begin
                rd_ptr1 <= rd_ptr1 + PTR_W'(1);
            end
            cnt1 <= next_count(cnt1, push1, pop1);
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.y0_valid = y0_valid;
    assign bus.y1_valid = y1_valid;
    assign bus.y0_data  = mem0[rd_ptr0];
    assign bus.y1_data  = mem1[rd_ptr1];
    assign bus.y0_count = cnt0;
    assign bus.y1_count = cnt1;

`ifdef DEMUX_2X1_STATS_EN
    logic [15:0] words0, words1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            words0 <= '0;
            words1 <= '0;
        end else begin
            if (push0) begin
                words0 <= sat_inc16(words0);
            end
            if (push1) begin
                words1 <= sat_inc16(words1);
            end
        end
    end

    assign bus.y0_words = words0;
    assign bus.y1_words = words1;
`endif
endmodule

// File: doc/demux_2x1_fifo.md
Name: demux_2x1_fifo

Overview:
- Registered, flow-controlled 1:2 demultiplexer stage.
- Accepts a valid/ready word stream with a per-word select bit and routes each word into one of two independent output FIFOs.
- Each FIFO drains on its own valid/ready port.
- Sits where the combinational 1:2 demux sits today. It is used when the two consumers can stall independently and need buffering.

Parameters:
- DATA_W, 8, width of data words.
- DEPTH, 4, entries per output FIFO; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy outputs (derived, do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input word present
- in_ready  out  1  input word can be accepted this cycle
- in_data  in  DATA_W  input word
- in_sel  in  1  route select: 0 -> y0, 1 -> y1
- y0_valid  out  1  y0 FIFO non-empty
- y0_ready  in  1  y0 consumer takes word
- y0_data  out  DATA_W  y0 head word
- y1_valid  out  1  y1 FIFO non-empty
- y1_ready  in  1  y1 consumer takes word
- y1_data  out  DATA_W  y1 head word
- y0_count  out  CNT_W  y0 occupancy
- y1_count  out  CNT_W  y1 occupancy

Behaviour:
Clocking and reset
- Single clock domain; all state updates on rising clk.
- rst (synchronous, active-high) clears both FIFOs: pointers = 0, counts = 0, y0_valid = y1_valid = 0.
- Storage RAM contents are not reset; y0_data/y1_data are don't-care while the matching valid is 0.
- Reset asserted mid-transfer discards all buffered words. Nothing is accepted or popped in a reset cycle.
- in_ready is 0 while rst is high.

Input side
- in_ready = (in_sel ? y1_count : y0_count) != DEPTH. It is combinational on in_sel and the registered counts.
- Transfer occurs when in_valid && in_ready. The word is written at the selected FIFO's write pointer and appears at that FIFO's output the next cycle: 1-cycle latency, first-word-fall-through.
- A full selected FIFO stalls the input even if the other FIFO has space: strict in-order, head-of-line blocking.
- No full-bypass: a full FIFO that is being popped in the same cycle still drives in_ready = 0.
- in_data and in_sel must be held stable while in_valid && !in_ready.

Output side, per FIFO
- yN_valid = (yN_count != 0).
- yN_data = mem[rd_ptr], registered storage.
- Pop when yN_valid && yN_ready. rd_ptr advances and the next entry is presented on the following cycle.
- yN_ready while empty is ignored.

Pointers and counts
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update per FIFO: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push into one FIFO and pop from the other are independent.
- Empty FIFO: push and pop cannot coincide, because valid = 0.
- Count never exceeds DEPTH and never underflows.

Optional Feature:
DEMUX_2X1_STATS_EN
- Defined: adds outputs y0_words and y1_words, 16 bits each.
- Each counts accepted input transfers routed to that output.
- Saturating at 16'hFFFF.
- Cleared by rst.
- Not defined: the ports and the counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then idle: rst high 2 cycles -> in_ready=1 (in_sel=0), y0_valid=y1_valid=0, counts=0.
- Route and latency: push 0xA5 sel=0 and 0x3C sel=1 with both readies=0 -> y0_data=0xA5 and y1_data=0x3C one cycle after each push; y0_count=1, y1_count=1.
- Full/stall: push 4 words sel=0 with y0_ready=0 -> y0_count=4; 5th word with sel=0 sees in_ready=0. Switching in_sel=1 gives in_ready=1 combinationally. Same-cycle y0_ready=1 still gives in_ready=0 for sel=0.
- Wrap-around and ordering: stream 0x00..0x0F all sel=1 with y1_ready toggling 1/0 -> y1 emits 0x00..0x0F in order, no loss or duplicate, count stays ≤4.
- Simultaneous push/pop: y0 holds 2 words; push sel=0 with y0_ready=1 -> y0_count stays 2, head advances.
- Reset mid-operation: both FIFOs at 3 entries, assert rst one cycle -> counts=0, valids=0, next push re-fills from empty. With DEMUX_2X1_STATS_EN: y0_words/y1_words reset to 0, and 70000 sel=0 accepts read 16'hFFFF.
